// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and SPI line idle levels for spi_master
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;
  localparam logic SCK_IDLE = 1'b0;
  localparam logic NSS_OFF = 1'b1;
endpackage

// File: rtl/spi_tick.sv
// spi_tick: half-period timer, ticks every div enabled cycles, restarts on clr
module spi_tick #(
  parameter int div = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(div);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(div - 1);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 MSB-first SPI initiator; SPI_MASTER_MISO_SYNC_EN adds a 2-flop miso synchronizer
module spi_master import spi_pkg::*; #(
  parameter int size = 8,
  parameter int div = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] di,
  output logic [size-1:0] dout,
  output logic            busy,
  output logic            done,
  output logic            sck,
  output logic            mosi,
  input  logic            miso,
  output logic            nss
);
  localparam int BW = $clog2(size);
  state_t state, nxt;
  logic tick, last, rise, cap, miso_s, sck_d, nss_d, busy_d;
  logic [size-1:0] tx, rx;
  logic [BW-1:0] bit_cnt;
  if (size < 2 || div < 2) begin : g_param_chk
    $error("spi_master needs size >= 2 and div >= 2");
  end
  spi_tick #(.div(div)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE),
    .en  (state != IDLE),
    .tick(tick)
  );
  assign last = bit_cnt == BW'(size - 1);
  assign rise = nxt == HIGH && state != HIGH;
`ifdef SPI_MASTER_MISO_SYNC_EN
  logic [1:0] sync, cap_d;
  if (div < 3) begin : g_sync_chk
    $error("spi_master with miso sync needs div >= 3");
  end
  // capture is delayed to line up with the synchronizer latency, still inside HIGH
  always_ff @(posedge clk)
    if (rst) begin
      sync <= '0;
      cap_d <= '0;
    end else begin
      sync <= {sync[0], miso};
      cap_d <= {cap_d[0], rise};
    end
  assign miso_s = sync[1];
  assign cap = cap_d[1];
`else
  assign miso_s = miso;
  assign cap = rise;
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = start ? SETUP : IDLE;
      SETUP:   nxt = tick ? HIGH : SETUP;
      HIGH:    nxt = tick ? LOW : HIGH;
      LOW:     nxt = tick ? (last ? HOLD : HIGH) : LOW;
      HOLD:    nxt = tick ? GAP : HOLD;
      GAP:     nxt = tick ? IDLE : GAP;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    sck_d = nxt == HIGH ? ~SCK_IDLE : SCK_IDLE;
    nss_d = (nxt == IDLE || nxt == GAP) ? NSS_OFF : ~NSS_OFF;
    busy_d = nxt != IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      sck <= SCK_IDLE;
      nss <= NSS_OFF;
      busy <= 1'b0;
      done <= 1'b0;
      dout <= '0;
      mosi <= 1'b0;
      tx <= '0;
      rx <= '0;
      bit_cnt <= '0;
    end else begin
      sck <= sck_d;
      nss <= nss_d;
      busy <= busy_d;
      done <= state == HOLD && tick;
      if (state == HOLD && tick) dout <= rx;
      if (cap) rx <= {rx[size-2:0], miso_s};
      if (state == IDLE && start) begin
        tx <= di;
        mosi <= di[size-1];
        bit_cnt <= '0;
      end
      // after the final fall mosi keeps the last bit
      if (state == HIGH && tick && !last) begin
        tx <= {tx[size-2:0], tx[size-1]};
        mosi <= tx[size-2];
      end
      if (state == LOW && tick && !last) bit_cnt <= bit_cnt + 1'b1;
    end
endmodule
